// File: rtl/vram_port_if.sv
// Port-A sharing bus for the text VRAM arbiter: CPU Avalon-MM slave, fill engine control,
// RAM port A and palette forwarding. FILL_ABORT exists only when FILL_ABORT_EN is defined.
interface vram_port_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              AVL_CS;
  logic              AVL_READ;
  logic              AVL_WRITE;
  logic [3:0]        AVL_BYTE_EN;
  logic [ADDR_W-1:0] AVL_ADDR;
  logic [DATA_W-1:0] AVL_WRITEDATA;
  logic [DATA_W-1:0] AVL_READDATA;
  logic              AVL_WAITREQUEST;

  logic              FILL_START;
  logic [ADDR_W-1:0] FILL_BASE;
  logic [ADDR_W-1:0] FILL_COUNT;
  logic [DATA_W-1:0] FILL_DATA;
  logic              FILL_BUSY;
  logic              FILL_DONE;
`ifdef FILL_ABORT_EN
  logic              FILL_ABORT;
`endif

  logic [ADDR_W-1:0] RAM_ADDR;
  logic [3:0]        RAM_BYTE_EN;
  logic [DATA_W-1:0] RAM_DATA;
  logic              RAM_RDEN;
  logic              RAM_WREN;
  logic [DATA_W-1:0] RAM_Q;

  logic              PAL_WE;
  logic [2:0]        PAL_IDX;
  logic [DATA_W-1:0] PAL_DATA;

  modport slave (
    input  AVL_CS, AVL_READ, AVL_WRITE, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
    output AVL_READDATA, AVL_WAITREQUEST,
    input  FILL_START, FILL_BASE, FILL_COUNT, FILL_DATA,
`ifdef FILL_ABORT_EN
    input  FILL_ABORT,
`endif
    output FILL_BUSY, FILL_DONE,
    output RAM_ADDR, RAM_BYTE_EN, RAM_DATA, RAM_RDEN, RAM_WREN,
    input  RAM_Q,
    output PAL_WE, PAL_IDX, PAL_DATA
  );

  modport master (
    output AVL_CS, AVL_READ, AVL_WRITE, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
    input  AVL_READDATA, AVL_WAITREQUEST,
    output FILL_START, FILL_BASE, FILL_COUNT, FILL_DATA,
`ifdef FILL_ABORT_EN
    output FILL_ABORT,
`endif
    input  FILL_BUSY, FILL_DONE,
    input  RAM_ADDR, RAM_BYTE_EN, RAM_DATA, RAM_RDEN, RAM_WREN,
    output RAM_Q,
    input  PAL_WE, PAL_IDX, PAL_DATA
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// Shares text-VRAM port A between the CPU Avalon slave and a word-fill engine; palette
// accesses bypass the RAM. Define FILL_ABORT_EN to add the FILL_ABORT input.
module vram_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int VRAM_WORDS = 1200,
  parameter int CPU_STREAK = 4
) (
  input logic       CLK,
  input logic       RESET,
  vram_port_if.slave bus
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FILL    = 2'd1;
  localparam logic [1:0] ST_RD_DATA = 2'd2;

  localparam int                    STREAK_W   = $clog2(CPU_STREAK + 1);
  localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(CPU_STREAK);
  localparam logic [ADDR_W-1:0]     VRAM_LIM   = ADDR_W'(VRAM_WORDS);
  localparam logic [ADDR_W-1:0]     ONE_A      = ADDR_W'(1);

  logic [1:0]          state_q, state_d;
  logic                fill_act_q, fill_act_d;
  logic                done_q, done_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   pat_q, pat_d;

  logic cpu_req, is_pal, is_oob, vram_req;
  logic cpu_grant, eng_grant, fill_end, abort_req;

  assign cpu_req  = bus.AVL_CS & (bus.AVL_READ | bus.AVL_WRITE);
  assign is_pal   = bus.AVL_ADDR[11];
  assign is_oob   = ~is_pal & (bus.AVL_ADDR >= VRAM_LIM);
  assign vram_req = cpu_req & ~is_pal & ~is_oob;

`ifdef FILL_ABORT_EN
  assign abort_req = bus.FILL_ABORT;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    fill_act_d = fill_act_q;
    done_d     = 1'b0;
    streak_d   = streak_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    pat_d      = pat_q;
    cpu_grant  = 1'b0;
    eng_grant  = 1'b0;
    fill_end   = 1'b0;

    bus.AVL_READDATA    = '0;
    bus.AVL_WAITREQUEST = 1'b0;
    bus.RAM_ADDR        = '0;
    bus.RAM_BYTE_EN     = 4'h0;
    bus.RAM_DATA        = '0;
    bus.RAM_RDEN        = 1'b0;
    bus.RAM_WREN        = 1'b0;
    bus.PAL_WE          = 1'b0;
    bus.PAL_IDX         = 3'd0;
    bus.PAL_DATA        = '0;

    if (state_q == ST_RD_DATA) begin
      // Read data returns this cycle; port A itself is idle and free for the engine.
      bus.AVL_READDATA = bus.RAM_Q;
      eng_grant        = fill_act_q;
    end else begin
      if (cpu_req && !vram_req) begin
        // Palette and out-of-range accesses complete at once without touching port A.
        bus.PAL_WE   = is_pal & bus.AVL_WRITE;
        bus.PAL_IDX  = (is_pal & bus.AVL_WRITE) ? bus.AVL_ADDR[2:0] : 3'd0;
        bus.PAL_DATA = (is_pal & bus.AVL_WRITE) ? bus.AVL_WRITEDATA : '0;
      end else if (vram_req) begin
        if (fill_act_q && streak_q == STREAK_MAX) begin
          bus.AVL_WAITREQUEST = 1'b1;
        end else begin
          cpu_grant           = 1'b1;
          bus.RAM_ADDR        = bus.AVL_ADDR;
          bus.RAM_BYTE_EN     = bus.AVL_BYTE_EN;
          bus.RAM_DATA        = bus.AVL_WRITE ? bus.AVL_WRITEDATA : '0;
          bus.RAM_WREN        = bus.AVL_WRITE;
          bus.RAM_RDEN        = ~bus.AVL_WRITE;
          bus.AVL_WAITREQUEST = ~bus.AVL_WRITE;
        end
      end
      eng_grant = fill_act_q & ~cpu_grant;
      streak_d  = (fill_act_q && cpu_grant) ? streak_q + STREAK_W'(1) : '0;
    end

    if (eng_grant) begin
      bus.RAM_ADDR    = ptr_q;
      bus.RAM_BYTE_EN = 4'hF;
      bus.RAM_DATA    = pat_q;
      bus.RAM_WREN    = 1'b1;
      ptr_d           = ptr_q + ONE_A;
      rem_d           = rem_q - ONE_A;
      // Clip at the end of the visible buffer rather than wrapping to word 0.
      fill_end        = (rem_q == ONE_A) || (ptr_q + ONE_A == VRAM_LIM);
    end

    if (fill_act_q && abort_req) begin
      fill_end = 1'b1;
    end

    if (fill_end) begin
      fill_act_d = 1'b0;
      done_d     = 1'b1;
    end

    if (!fill_act_q && bus.FILL_START) begin
      if (bus.FILL_COUNT != '0 && bus.FILL_BASE < VRAM_LIM) begin
        fill_act_d = 1'b1;
        ptr_d      = bus.FILL_BASE;
        rem_d      = bus.FILL_COUNT;
        pat_d      = bus.FILL_DATA;
        streak_d   = '0;
      end else begin
        done_d = 1'b1;
      end
    end

    if (cpu_grant && !bus.AVL_WRITE) begin
      state_d = ST_RD_DATA;
    end else begin
      state_d = fill_act_d ? ST_FILL : ST_IDLE;
    end

    bus.FILL_BUSY = fill_act_q;
    bus.FILL_DONE = done_q;

    if (!RESET) begin
      bus.AVL_READDATA    = '0;
      bus.AVL_WAITREQUEST = 1'b1;
      bus.RAM_ADDR        = '0;
      bus.RAM_BYTE_EN     = 4'h0;
      bus.RAM_DATA        = '0;
      bus.RAM_RDEN        = 1'b0;
      bus.RAM_WREN        = 1'b0;
      bus.PAL_WE          = 1'b0;
      bus.PAL_IDX         = 3'd0;
      bus.PAL_DATA        = '0;
      bus.FILL_BUSY       = 1'b0;
      bus.FILL_DONE       = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      fill_act_q <= 1'b0;
      done_q     <= 1'b0;
      streak_q   <= '0;
    end else begin
      state_q    <= state_d;
      fill_act_q <= fill_act_d;
      done_q     <= done_d;
      streak_q   <= streak_d;
    end
    ptr_q <= ptr_d;
    rem_q <= rem_d;
    pat_q <= pat_d;
  end
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a behavioural port-A RAM and a fill-write monitor.
module tb_vram_port_arbiter;
  logic CLK = 1'b0;
  logic RESET;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  vram_port_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  vram_port_arbiter #(.ADDR_W(12), .DATA_W(32), .VRAM_WORDS(1200), .CPU_STREAK(4)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #10 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Port-A RAM model: 1-cycle read latency, byte-enabled writes.
  logic [31:0] mem [0:4095];
  logic [31:0] q_pend;
  always @(negedge CLK) begin
    if (bus.RAM_RDEN) q_pend <= mem[bus.RAM_ADDR];
    if (bus.RAM_WREN)
      for (int b = 0; b < 4; b++)
        if (bus.RAM_BYTE_EN[b]) mem[bus.RAM_ADDR][b*8 +: 8] <= bus.RAM_DATA[b*8 +: 8];
  end
  always @(posedge CLK) bus.RAM_Q <= q_pend;

  // Per-fill statistics; a FILL_START opens a new epoch.
  logic [31:0] cur_pat;
  int ep_wr, ep_addr_err, ep_gap, ep_done_cnt, ep_done_cyc, start_cyc;
  int ep_first_addr, ep_last_addr, ep_first_cyc, ep_last_cyc;
  logic busy_at_done;
  always @(negedge CLK) begin
    if (bus.FILL_START) begin
      ep_wr <= 0; ep_addr_err <= 0; ep_gap <= 0; ep_done_cnt <= 0; start_cyc <= cyc;
      ep_first_addr <= -1; ep_last_addr <= -1; ep_first_cyc <= -1; ep_last_cyc <= -1;
    end else begin
      if (RESET && bus.RAM_WREN && bus.RAM_DATA == cur_pat && bus.RAM_BYTE_EN == 4'hF) begin
        ep_wr <= ep_wr + 1;
        if (ep_wr == 0) begin
          ep_first_addr <= int'(bus.RAM_ADDR);
          ep_first_cyc  <= cyc;
        end else begin
          if (int'(bus.RAM_ADDR) != ep_last_addr + 1) ep_addr_err <= ep_addr_err + 1;
          if (cyc != ep_last_cyc + 1) ep_gap <= ep_gap + 1;
        end
        ep_last_addr <= int'(bus.RAM_ADDR);
        ep_last_cyc  <= cyc;
      end
      if (bus.FILL_DONE) begin
        ep_done_cnt  <= ep_done_cnt + 1;
        ep_done_cyc  <= cyc;
        busy_at_done <= bus.FILL_BUSY;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_fill(input logic [11:0] base, input logic [11:0] cnt, input logic [31:0] d);
    cur_pat        = d;
    bus.FILL_BASE  = base;
    bus.FILL_COUNT = cnt;
    bus.FILL_DATA  = d;
    bus.FILL_START = 1'b1;
    step();
    bus.FILL_START = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      if (ep_done_cnt != 0) break;
      step();
    end
    check({tag, "_done_seen"}, 32'(ep_done_cnt != 0), 32'd1);
  endtask

  task automatic cpu_xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int waits);
    bus.AVL_CS = 1'b1; bus.AVL_WRITE = wr; bus.AVL_READ = ~wr;
    bus.AVL_ADDR = a; bus.AVL_WRITEDATA = d; bus.AVL_BYTE_EN = 4'hF;
    waits = 0; rd = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (!bus.AVL_WAITREQUEST) begin
        rd = bus.AVL_READDATA;
        break;
      end
      waits++;
      step();
    end
    step();
    bus.AVL_CS = 1'b0; bus.AVL_WRITE = 1'b0; bus.AVL_READ = 1'b0;
  endtask

  logic [31:0] rd;
  int waits, stalls, run, maxrun, i;
  logic acc;

  initial begin
    RESET = 1'b0;
    bus.AVL_CS = 1'b0; bus.AVL_READ = 1'b0; bus.AVL_WRITE = 1'b0; bus.AVL_BYTE_EN = 4'h0;
    bus.AVL_ADDR = '0; bus.AVL_WRITEDATA = '0;
    bus.FILL_START = 1'b0; bus.FILL_BASE = '0; bus.FILL_COUNT = '0; bus.FILL_DATA = '0;
`ifdef FILL_ABORT_EN
    bus.FILL_ABORT = 1'b0;
`endif
    cur_pat = 32'hFFFF_FFFF;

    // Reset holds off a pending CPU write and forces waitrequest high.
    bus.AVL_CS = 1'b1; bus.AVL_WRITE = 1'b1; bus.AVL_ADDR = 12'd7; bus.AVL_BYTE_EN = 4'hF;
    step(); step();
    @(negedge CLK);
    check("rst_wait", 32'(bus.AVL_WAITREQUEST), 32'd1);
    check("rst_wren", 32'(bus.RAM_WREN), 32'd0);
    check("rst_busy", 32'(bus.FILL_BUSY), 32'd0);
    check("rst_done", 32'(bus.FILL_DONE), 32'd0);
    step();
    bus.AVL_CS = 1'b0; bus.AVL_WRITE = 1'b0;
    RESET = 1'b1;
    step();

    // Full-screen fill with no CPU traffic.
    start_fill(12'd0, 12'd1200, 32'h0F20_0F20);
    wait_done(1300, "fill");
    step(); step();
    check("fill_count", 32'(ep_wr), 32'd1200);
    check("fill_first", 32'(ep_first_addr), 32'd0);
    check("fill_last", 32'(ep_last_addr), 32'd1199);
    check("fill_seq", 32'(ep_addr_err), 32'd0);
    check("fill_gapless", 32'(ep_gap), 32'd0);
    check("fill_first_lat", 32'(ep_first_cyc - start_cyc), 32'd1);
    check("fill_done_lat", 32'(ep_done_cyc - ep_last_cyc), 32'd1);
    check("fill_busy_at_done", 32'(busy_at_done), 32'd0);
    check("fill_done_pulse", 32'(ep_done_cnt), 32'd1);
    check("fill_mem1199", mem[1199], 32'h0F20_0F20);

    // CPU write then read back through the RD_DATA state.
    cpu_xfer(1'b1, 12'd5, 32'hDEAD_BEEF, rd, waits);
    check("wr_waits", 32'(waits), 32'd0);
    check("wr_mem5", mem[5], 32'hDEAD_BEEF);
    cpu_xfer(1'b0, 12'd5, 32'h0, rd, waits);
    check("rd_waits", 32'(waits), 32'd1);
    check("rd_data", rd, 32'hDEAD_BEEF);

    // Contention: back-to-back CPU writes to word 1000 while a 10-word fill runs.
    cur_pat = 32'h1111_1111;
    bus.FILL_BASE = 12'd0; bus.FILL_COUNT = 12'd10; bus.FILL_DATA = 32'h1111_1111;
    bus.FILL_START = 1'b1;
    bus.AVL_CS = 1'b1; bus.AVL_WRITE = 1'b1; bus.AVL_ADDR = 12'd1000;
    bus.AVL_WRITEDATA = 32'hC0DE_0000; bus.AVL_BYTE_EN = 4'hF;
    stalls = 0; run = 0; maxrun = 0;
    for (i = 0; i < 80; i++) begin
      @(negedge CLK);
      if (bus.AVL_WAITREQUEST) begin
        stalls++; run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
      acc = ~bus.AVL_WAITREQUEST;
      step();
      bus.FILL_START = 1'b0;
      if (acc) bus.AVL_WRITEDATA = bus.AVL_WRITEDATA + 32'd1;
      if (ep_done_cnt != 0) break;
    end
    bus.AVL_CS = 1'b0; bus.AVL_WRITE = 1'b0;
    check("cont_done_seen", 32'(ep_done_cnt), 32'd1);
    check("cont_fill_writes", 32'(ep_wr), 32'd10);
    check("cont_first_eng", 32'(ep_first_cyc - start_cyc), 32'd5);
    check("cont_last_eng", 32'(ep_last_cyc - start_cyc), 32'd50);
    check("cont_last_addr", 32'(ep_last_addr), 32'd9);
    check("cont_stalls", 32'(stalls), 32'd10);
    check("cont_max_stall", 32'(maxrun), 32'd1);
    step();

    // Fill clipped at the end of VRAM.
    start_fill(12'd1195, 12'd20, 32'hA5A5_A5A5);
    wait_done(60, "clip");
    check("clip_count", 32'(ep_wr), 32'd5);
    check("clip_first", 32'(ep_first_addr), 32'd1195);
    check("clip_last", 32'(ep_last_addr), 32'd1199);
    check("clip_done_lat", 32'(ep_done_cyc - ep_last_cyc), 32'd1);
    step();

    // Degenerate starts: zero count and out-of-range base.
    start_fill(12'd10, 12'd0, 32'h2222_2222);
    wait_done(10, "cnt0");
    check("cnt0_writes", 32'(ep_wr), 32'd0);
    check("cnt0_done_lat", 32'(ep_done_cyc - start_cyc), 32'd1);
    check("cnt0_busy", 32'(busy_at_done), 32'd0);
    step();
    start_fill(12'd1300, 12'd5, 32'h3333_3333);
    wait_done(10, "base_oob");
    check("base_oob_writes", 32'(ep_wr), 32'd0);
    step();

    // Palette write bypasses the RAM.
    bus.AVL_CS = 1'b1; bus.AVL_WRITE = 1'b1; bus.AVL_ADDR = 12'h803;
    bus.AVL_WRITEDATA = 32'h00AB_C000;
    @(negedge CLK);
    check("pal_we", 32'(bus.PAL_WE), 32'd1);
    check("pal_idx", 32'(bus.PAL_IDX), 32'd3);
    check("pal_data", bus.PAL_DATA, 32'h00AB_C000);
    check("pal_wren", 32'(bus.RAM_WREN), 32'd0);
    check("pal_wait", 32'(bus.AVL_WAITREQUEST), 32'd0);
    step();
    bus.AVL_CS = 1'b0; bus.AVL_WRITE = 1'b0;
    @(negedge CLK);
    check("pal_we_drop", 32'(bus.PAL_WE), 32'd0);
    step();

    // Palette read and out-of-range accesses return immediately.
    mem[1200] = 32'h9999_9999;
    cpu_xfer(1'b0, 12'h805, 32'h0, rd, waits);
    check("palrd_waits", 32'(waits), 32'd0);
    check("palrd_data", rd, 32'h0);
    cpu_xfer(1'b0, 12'd1200, 32'h0, rd, waits);
    check("oobrd_waits", 32'(waits), 32'd0);
    check("oobrd_data", rd, 32'h0);
    bus.AVL_CS = 1'b1; bus.AVL_WRITE = 1'b1; bus.AVL_ADDR = 12'd1200;
    bus.AVL_WRITEDATA = 32'h4444_4444;
    @(negedge CLK);
    check("oobwr_wren", 32'(bus.RAM_WREN), 32'd0);
    check("oobwr_wait", 32'(bus.AVL_WAITREQUEST), 32'd0);
    step();
    bus.AVL_CS = 1'b0; bus.AVL_WRITE = 1'b0;
    step();

    // Reset in the middle of a fill: the 101st write never happens and DONE stays low.
    start_fill(12'd0, 12'd1200, 32'h7777_7777);
    for (i = 0; i < 200; i++) begin
      if (ep_wr >= 100) break;
      step();
    end
    RESET = 1'b0;
    @(negedge CLK);
    check("rstfill_wren", 32'(bus.RAM_WREN), 32'd0);
    step(); step();
    RESET = 1'b1;
    repeat (20) step();
    check("rstfill_writes", 32'(ep_wr), 32'd100);
    check("rstfill_busy", 32'(bus.FILL_BUSY), 32'd0);
    check("rstfill_no_done", 32'(ep_done_cnt), 32'd0);
    check("rstfill_mem99", mem[99], 32'h7777_7777);
    check("rstfill_mem100", mem[100], 32'h0F20_0F20);

`ifdef FILL_ABORT_EN
    // Abort raised in the cycle that writes word 100.
    start_fill(12'd0, 12'd1200, 32'h5555_5555);
    for (i = 0; i < 200; i++) begin
      if (ep_wr >= 100) break;
      step();
    end
    bus.FILL_ABORT = 1'b1;
    step();
    bus.FILL_ABORT = 1'b0;
    wait_done(10, "abort");
    step(); step();
    check("abort_writes", 32'(ep_wr), 32'd101);
    check("abort_last", 32'(ep_last_addr), 32'd100);
    check("abort_done_lat", 32'(ep_done_cyc - ep_last_cyc), 32'd1);
    check("abort_busy", 32'(busy_at_done), 32'd0);
    check("abort_mem101", mem[101], 32'h0F20_0F20);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
